// File: rtl/data_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_pkg
// Shared definitions for the data-memory controller:
//   - bus widths (32-bit byte address, 32-bit data)
//   - mem_op_i operation codes (LB, LBU, LH, LHU, LW, SB, SH, SW)
//   - controller state encodings
//   - helpers classifying an operation as a load / as misaligned
// ---------------------------------------------------------------------------
package data_mem_ctrl_pkg;

  localparam int DATA_ADDR_W = 32;
  localparam int DATA_W      = 32;

  // Operation codes carried on mem_op_i.
  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  // Controller states.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_RMW_MG = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_WR_H   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  function automatic logic is_load(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  // Halves must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(input logic [2:0] op,
                                         input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: mis = offset[0];
      OP_LW, OP_SW:         mis = (offset != 2'b00);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_lane.sv
// ---------------------------------------------------------------------------
// mem_lane
// Purely combinational lane logic for the data-memory controller, using
// big-endian lane order (byte offset 0 = bits [31:24], half offset 0 =
// bits [31:16]).
//   op         : operation code of the access in flight
//   offset     : byte offset addr[1:0] of the access
//   word_in    : word read from RAM
//   store_data : store data (byte in [7:0], half in [15:0])
//   load_data  : selected lane, sign/zero extended (LW passes through)
//   merged     : word_in with the store lane replaced (SB/SH)
// ---------------------------------------------------------------------------
module mem_lane
  import data_mem_ctrl_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] word_in,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    lane_byte = 8'h00;
    lane_half = 16'h0000;
    load_data = '0;
    merged    = word_in;

    case (offset)
      2'd0:    lane_byte = word_in[31:24];
      2'd1:    lane_byte = word_in[23:16];
      2'd2:    lane_byte = word_in[15:8];
      default: lane_byte = word_in[7:0];
    endcase
    lane_half = offset[1] ? word_in[15:0] : word_in[31:16];

    case (op)
      OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_data = {24'h000000, lane_byte};
      OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_data = {16'h0000, lane_half};
      OP_LW:   load_data = word_in;
      default: load_data = '0;
    endcase

    case (op)
      OP_SB: begin
        case (offset)
          2'd0:    merged[31:24] = store_data[7:0];
          2'd1:    merged[23:16] = store_data[7:0];
          2'd2:    merged[15:8]  = store_data[7:0];
          default: merged[7:0]   = store_data[7:0];
        endcase
      end
      OP_SH: begin
        if (offset[1]) merged[15:0]  = store_data[15:0];
        else           merged[31:16] = store_data[15:0];
      end
      default: merged = word_in;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// MEM-stage data-memory controller. Loads read one word and extract a lane;
// SW writes the word directly; SB/SH read-modify-write. Misaligned accesses
// finish in the request cycle with err_o and never touch the RAM.
// Pipeline side:
//   clk, rst   : clock, asynchronous active-high reset
//   req_i      : access request (held stable while stall_o=1)
//   mem_op_i   : operation code (see data_mem_ctrl_pkg)
//   addr_i     : byte address
//   wdata_i    : store data
//   rdata_o    : extended load result, valid in the DONE cycle of a load
//   done_o     : completion pulse
//   err_o      : misalignment pulse (with done_o)
//   stall_o    : pipeline hold
// RAM side:
//   mem_ce_o, mem_we_o, mem_addr_o (word aligned), mem_data_o (write word),
//   mem_data_i (read word, valid the cycle after a read), mem_ack_i
// ---------------------------------------------------------------------------
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic [2:0]             mem_op_i,
  input  logic [DATA_ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]      wdata_i,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   stall_o,
  output logic                   mem_ce_o,
  output logic                   mem_we_o,
  output logic [DATA_ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]      mem_data_o,
  input  logic [DATA_W-1:0]      mem_data_i,
  input  logic                   mem_ack_i
);

  logic [2:0]        state, state_nxt;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic              mis_req;
  logic              aligned_req;
  logic              accept;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  assign mis_req     = req_i &&  is_misaligned(mem_op_i, addr_i[1:0]);
  assign aligned_req = req_i && !is_misaligned(mem_op_i, addr_i[1:0]);
  assign accept      = (state == S_IDLE) && aligned_req;

  // Lane logic works on the latched op/offset so DONE does not depend on the
  // pipeline still presenting the request.
  mem_lane u_lane (
    .op         (op_q),
    .offset     (off_q),
    .word_in    (mem_data_i),
    .store_data (wdata_i),
    .load_data  (load_data),
    .merged     (merged)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_load(mem_op_i))      state_nxt = S_RD;
          else if (mem_op_i == OP_SW) state_nxt = S_WR;
          else                        state_nxt = S_RMW_RD;
        end
      end
      S_RD:     state_nxt = S_DONE;
      S_RMW_RD: state_nxt = S_RMW_MG;
      S_RMW_MG: state_nxt = S_WR;
      // The RAM first drops ack, then raises it for the actual write.
      S_WR:     state_nxt = mem_ack_i ? S_WR : S_WR_H;
      S_WR_H:   state_nxt = mem_ack_i ? S_DONE : S_WR_H;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= OP_LB;
      off_q      <= 2'b00;
      // NOTE: mem_data_o is a single register, not a storage array, so it is
      // cleared by reset like any other control flop.
      mem_data_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= mem_op_i;
        off_q <= addr_i[1:0];
        if (mem_op_i == OP_SW) mem_data_o <= wdata_i;
      end
      if (state == S_RMW_MG) mem_data_o <= merged;
    end
  end

  assign mem_ce_o   = (state == S_RD) || (state == S_RMW_RD) ||
                      (state == S_WR) || (state == S_WR_H);
  assign mem_we_o   = (state == S_WR) || (state == S_WR_H);
  // Combinational outputs are forced low while reset is held.
  assign mem_addr_o = rst ? '0 : {addr_i[DATA_ADDR_W-1:2], 2'b00};
  assign done_o     = !rst && ((state == S_DONE) ||
                               ((state == S_IDLE) && mis_req));
  assign err_o      = !rst && (state == S_IDLE) && mis_req;
  assign stall_o    = !rst && (((state == S_IDLE) && aligned_req) ||
                               ((state != S_IDLE) && (state != S_DONE)));
  assign rdata_o    = ((state == S_DONE) && is_load(op_q)) ? load_data : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed bench for data_mem_ctrl with a small behavioural RAM: reads are
// registered (data the cycle after ce & !we), writes drop ack for one cycle
// then raise it and commit on the ack edge.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  mem_op;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [31:0] rdata_o;
  logic        done_o, err_o, stall_o;
  logic        mem_ce_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [31:0] rd_q = 32'h0;
  logic        ack_r = 1'b0;
  logic [31:0] ram [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .mem_op_i   (mem_op),
    .addr_i     (addr_in),
    .wdata_i    (wdata_in),
    .rdata_o    (rdata_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .stall_o    (stall_o),
    .mem_ce_o   (mem_ce_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (rd_q),
    .mem_ack_i  (ack_r)
  );

  always @(posedge clk) begin
    if (mem_ce_o && !mem_we_o) rd_q <= ram[mem_addr_o[9:2]];
    if (mem_ce_o && mem_we_o && ack_r) ram[mem_addr_o[9:2]] <= mem_data_o;
    ack_r <= mem_ce_o && mem_we_o && !ack_r;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request at the next falling edge and follows it to done_o.
  // Cycle 1 is the request cycle; the task returns inside the done cycle.
  task automatic access(input string tag, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_cycles, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int          cyc = 0;
    bit          seen = 1'b0;
    bit          ce_seen = 1'b0;
    bit          leak = 1'b0;
    logic        first_stall = 1'b0;
    logic        got_err = 1'b0;
    logic        got_stall = 1'b0;
    logic [31:0] got_rdata = 32'h0;
    @(negedge clk);
    req = 1'b1; mem_op = op; addr_in = addr; wdata_in = wdata;
    while (!seen && cyc < 20) begin
      #1;
      cyc++;
      if (cyc == 1) first_stall = stall_o;
      if (mem_ce_o) ce_seen = 1'b1;
      if (done_o) begin
        seen = 1'b1;
        got_rdata = rdata_o;
        got_err = err_o;
        got_stall = stall_o;
      end else begin
        if (rdata_o !== 32'h0) leak = 1'b1;
        @(negedge clk);
      end
    end
    check({tag, "/done"},       32'(seen),        32'd1);
    check({tag, "/cycles"},     32'(cyc),         32'(exp_cycles));
    check({tag, "/rdata"},      got_rdata,        exp_rdata);
    check({tag, "/err"},        32'(got_err),     32'(exp_err));
    check({tag, "/done_stall"}, 32'(got_stall),   32'd0);
    check({tag, "/req_stall"},  32'(first_stall), 32'(!exp_err));
    check({tag, "/ce_seen"},    32'(ce_seen),     32'(!exp_err));
    check({tag, "/rdata_idle"}, 32'(leak),        32'd0);
  endtask

  initial begin
    // Reset with an aligned and then a misaligned request presented.
    rst = 1'b1; req = 1'b1; mem_op = OP_LW; addr_in = 32'h20;
    wdata_in = 32'hFFFF_FFFF;
    #2;
    check("rst/stall",    32'(stall_o),  32'd0);
    check("rst/done",     32'(done_o),   32'd0);
    check("rst/rdata",    rdata_o,       32'h0);
    check("rst/ce",       32'(mem_ce_o), 32'd0);
    check("rst/we",       32'(mem_we_o), 32'd0);
    check("rst/mem_addr", mem_addr_o,    32'h0);
    check("rst/mem_data", mem_data_o,    32'h0);
    mem_op = OP_SH; addr_in = 32'h33;
    #1;
    check("rst/mis_done", 32'(done_o),   32'd0);
    check("rst/mis_err",  32'(err_o),    32'd0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    #1;
    check("idle/stall",   32'(stall_o),  32'd0);
    check("idle/done",    32'(done_o),   32'd0);

    // Preload through the controller.
    access("sw10", OP_SW, 32'h10, 32'h11223344, 4, 32'h0, 1'b0);
    access("sw30", OP_SW, 32'h30, 32'h11223344, 4, 32'h0, 1'b0);
    check("ram10", ram[4],  32'h11223344);
    check("ram30", ram[12], 32'h11223344);

    // Loads and lane selection.
    access("lb13",  OP_LB,  32'h13, 32'h0, 3, 32'h00000044, 1'b0);
    access("lh12",  OP_LH,  32'h12, 32'h0, 3, 32'h00003344, 1'b0);
    access("lhu10", OP_LHU, 32'h10, 32'h0, 3, 32'h00001122, 1'b0);
    access("lw10",  OP_LW,  32'h10, 32'h0, 3, 32'h11223344, 1'b0);

    // Negative byte at offset 0, then sign/zero extension.
    access("sb10",  OP_SB,  32'h10, 32'h77777780, 6, 32'h0, 1'b0);
    check("ram10_sb", ram[4], 32'h80223344);
    access("lb10",  OP_LB,  32'h10, 32'h0, 3, 32'hFFFFFF80, 1'b0);
    access("lbu10", OP_LBU, 32'h10, 32'h0, 3, 32'h00000080, 1'b0);
    access("lh10",  OP_LH,  32'h10, 32'h0, 3, 32'hFFFF8022, 1'b0);

    // SW then LW to the same address with no idle gap.
    access("sw20",  OP_SW,  32'h20, 32'hDEADBEEF, 4, 32'h0, 1'b0);
    access("lw20",  OP_LW,  32'h20, 32'h0, 3, 32'hDEADBEEF, 1'b0);

    // Read-modify-write lanes; upper wdata bits must be ignored.
    access("sb31",  OP_SB,  32'h31, 32'h123456AA, 6, 32'h0, 1'b0);
    check("ram30_sb", ram[12], 32'h11AA3344);
    access("sh32",  OP_SH,  32'h32, 32'h9999BBCC, 6, 32'h0, 1'b0);
    check("ram30_sh", ram[12], 32'h11AABBCC);
    access("lhu32", OP_LHU, 32'h32, 32'h0, 3, 32'h0000BBCC, 1'b0);
    access("lh30",  OP_LH,  32'h30, 32'h0, 3, 32'h000011AA, 1'b0);

    // Misaligned accesses finish in the request cycle.
    access("lw21",  OP_LW,  32'h21, 32'h0, 1, 32'h0, 1'b1);
    access("sh33",  OP_SH,  32'h33, 32'h0000FFFF, 1, 32'h0, 1'b1);
    access("lh11",  OP_LH,  32'h11, 32'h0, 1, 32'h0, 1'b1);
    access("sw22",  OP_SW,  32'h22, 32'h0BADF00D, 1, 32'h0, 1'b1);
    check("ram20_mis", ram[8], 32'hDEADBEEF);

    // Reset during WR_H of an SW.
    @(negedge clk);
    req = 1'b1; mem_op = OP_SW; addr_in = 32'h20; wdata_in = 32'h12345678;
    #1;
    check("rstwr/req_stall", 32'(stall_o), 32'd1);
    @(negedge clk); #1;
    check("rstwr/wr_we",  32'(mem_we_o), 32'd1);
    check("rstwr/wr_ack", 32'(ack_r),    32'd0);
    @(negedge clk); #1;
    check("rstwr/wrh_we",   32'(mem_we_o), 32'd1);
    check("rstwr/wrh_ack",  32'(ack_r),    32'd1);
    check("rstwr/wrh_data", mem_data_o,    32'h12345678);
    check("rstwr/wrh_addr", mem_addr_o,    32'h20);
    rst = 1'b1;
    #1;
    check("rstwr/ce",    32'(mem_ce_o), 32'd0);
    check("rstwr/we",    32'(mem_we_o), 32'd0);
    check("rstwr/done",  32'(done_o),   32'd0);
    check("rstwr/stall", 32'(stall_o),  32'd0);
    @(negedge clk);
    check("rstwr/done2", 32'(done_o),   32'd0);
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check("rstwr/ram", ram[8], 32'hDEADBEEF);
    access("lw20_after", OP_LW, 32'h20, 32'h0, 3, 32'hDEADBEEF, 1'b0);

    @(negedge clk);
    req = 1'b0;
    #1;
    check("end/stall", 32'(stall_o), 32'd0);
    check("end/rdata", rdata_o,      32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have no parameters; widths come from the shared defines: `DataAddrBus` is 32 bits and `DataBus` is 32 bits.
REQ-002 SHALL have port `clk`: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port `req_i`: input, 1 bit, MEM-stage access request, held stable while `stall_o`=1.
REQ-005 SHALL have port `mem_op_i`: input, 3 bits, operation code: LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-006 SHALL have port `addr_i`: input, 32 bits, byte address.
REQ-007 SHALL have port `wdata_i`: input, 32 bits, store data; the byte is bits [7:0] and the half is bits [15:0].
REQ-008 SHALL have port `rdata_o`: output, 32 bits, sign- or zero-extended load result.
REQ-009 SHALL have port `done_o`: output, 1 bit, single-cycle completion pulse.
REQ-010 SHALL have port `err_o`: output, 1 bit, misalignment pulse, asserted together with `done_o`.
REQ-011 SHALL have port `stall_o`: output, 1 bit, pipeline hold.
REQ-012 SHALL have RAM-side ports: `mem_ce_o` out 1, `mem_we_o` out 1, `mem_addr_o` out 32, `mem_data_o` out 32, `mem_data_i` in 32, `mem_ack_i` in 1.

Function
REQ-013 SHALL implement the states IDLE, RD, RMW_RD, RMW_MG, WR, WR_H and DONE.
REQ-014 SHALL define `mem_addr_o` as {`addr_i`[31:2], 2'b00}; `mem_ce_o`=1 only in RD, RMW_RD, WR and WR_H; `mem_we_o`=1 only in WR and WR_H.
REQ-015 SHALL transition from IDLE when `req_i`=1 and the access is aligned: loads go to RD, SW goes to WR, SB/SH go to RMW_RD.
REQ-016 SHALL treat LH/LHU/SH with `addr_i`[0]=1, or LW/SW with `addr_i`[1:0]≠0, as misaligned: in IDLE, assert `done_o`=1 and `err_o`=1 combinationally, keep `stall_o`=0, issue no RAM access and stay in IDLE.
REQ-017 SHALL transition RD→DONE unconditionally; in DONE after a load, `rdata_o` is taken from the `mem_data_i` word.
REQ-018 SHALL transition RMW_RD→RMW_MG; in RMW_MG, register the merged word (old word with the selected lane replaced by store data) into `mem_data_o`, then go to WR.
REQ-019 SHALL stay in WR while `mem_ack_i`=1 and go to WR_H on `mem_ack_i`=0.
REQ-020 SHALL stay in WR_H while `mem_ack_i`=0 and go to DONE on `mem_ack_i`=1; the RAM writes at that edge.
REQ-021 SHALL hold `mem_addr_o` and `mem_data_o` constant through WR and WR_H.
REQ-022 SHALL, in DONE, assert `done_o`=1 and `stall_o`=0, then return to IDLE.
REQ-023 SHALL assert `stall_o`=1 in IDLE with an aligned `req_i`, and in every state other than IDLE and DONE.
REQ-024 SHALL use big-endian lane order: byte offset 0 is bits [31:24] and offset 3 is bits [7:0]; half offset 0 is bits [31:16].
REQ-025 SHALL extend loads as follows: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-026 SHALL keep `rdata_o`=0 outside DONE-after-load.
REQ-027 SHALL, for stores, drive `rdata_o`=0 in DONE.
REQ-028 SHALL have these cycle counts including the request cycle: loads 3, SW 4, SB/SH 6, provided the RAM acks as specified.
REQ-029 SHALL ignore `req_i` in every state except IDLE; a back-to-back request is accepted in the IDLE cycle following DONE.

Reset
REQ-030 SHALL, on `rst`=1 asynchronously, enter IDLE and clear `mem_data_o`, the merge register and all pulses, deasserting `mem_ce_o` and `mem_we_o` immediately.
REQ-031 SHALL hold outputs at zero while `rst`=1: `stall_o`, `done_o`, `err_o`, `rdata_o`, `mem_ce_o`, `mem_we_o`, `mem_addr_o`, `mem_data_o`.
REQ-032 SHALL, on reset mid-operation, abandon the access with no `done_o`; a partial RMW leaves memory unmodified unless the write edge already occurred.

Structure
REQ-033 SHALL define the `mem_op_i` codes and state encodings in the shared `defines.v`.
REQ-034 SHALL place lane extract/extend and lane merge in one combinational sub-module, `mem_lane`.
REQ-035 SHALL use a single registered state machine in `data_mem_ctrl`.

Verification
REQ-036 SHALL cover: memory word 0x11223344 at 0x10, LB 0x13 → `rdata_o`=0x00000044; LB 0x10 with byte 0x80 → 0xFFFFFF80; LBU → 0x00000080.
REQ-037 SHALL cover: SW 0xDEADBEEF to 0x20 → ack low for 1 cycle, `done_o` in cycle 4, then LW 0x20 → 0xDEADBEEF.
REQ-038 SHALL cover: word 0x11223344 at 0x30, SB 0xAA to 0x31 → word 0x11AA3344; SH 0xBBCC to 0x32 → 0x11AABBCC; each done in cycle 6.
REQ-039 SHALL cover: LW 0x21 and SH 0x33 → `done_o`=`err_o`=1 in the request cycle, `stall_o`=0, `mem_ce_o` never asserted.
REQ-040 SHALL cover: `rst` asserted during WR_H of an SW → `mem_ce_o`/`mem_we_o` drop immediately, no `done_o`, and the target word is unchanged.
REQ-041 SHALL cover: LW immediately after SW to the same address, with no idle gap → the new data is returned.
